// File: rtl/logic_unit_pkg.sv
// Shared opcode constants for the pipelined logic unit.
// Optional popcount output is enabled by defining LOGIC_UNIT_POPCNT_EN.
package logic_unit_pkg;

  localparam int OPSEL_W = 3;

  localparam logic [OPSEL_W-1:0] OP_AND  = 3'b000;
  localparam logic [OPSEL_W-1:0] OP_OR   = 3'b001;
  localparam logic [OPSEL_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OPSEL_W-1:0] OP_XNOR = 3'b011;
  localparam logic [OPSEL_W-1:0] OP_NAND = 3'b100;
  localparam logic [OPSEL_W-1:0] OP_NOR  = 3'b101;
  localparam logic [OPSEL_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OPSEL_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_stage.sv
// Generic valid/ready pipeline register; full throughput, the stage refills
// on the same edge its contents are taken downstream.
module logic_unit_stage
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  // Data only changes on an actual load, so it stays stable under stall
  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit with zero/ones/parity flags.
// Define LOGIC_UNIT_POPCNT_EN to add a registered popcount output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [OPSEL_W-1:0] opsel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               zero,
  output logic               ones,
  output logic               parity
`ifdef LOGIC_UNIT_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  localparam int PCW  = $clog2(WIDTH + 1);
  localparam int S1_W = 2 * WIDTH + OPSEL_W;
`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int S2_W = WIDTH + 3 + PCW;
`else
  localparam int S2_W = WIDTH + 3;
`endif

  logic               s1_valid;
  logic [S1_W-1:0]    s1_data;
  logic [WIDTH-1:0]   s1_op1, s1_op2;
  logic [OPSEL_W-1:0] s1_opsel;
  logic               s2_in_ready;
  logic [S2_W-1:0]    s2_in_data, s2_out_data;

  logic [WIDTH-1:0]   res;
  logic               res_zero, res_ones, res_parity;

  logic_unit_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({opsel, op2, op1}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign {s1_opsel, s1_op2, s1_op1} = s1_data;

  always_comb begin
    res = '0;
    case (s1_opsel)
      OP_AND:  res = s1_op1 & s1_op2;
      OP_OR:   res = s1_op1 | s1_op2;
      OP_XOR:  res = s1_op1 ^ s1_op2;
      OP_XNOR: res = ~(s1_op1 ^ s1_op2);
      OP_NAND: res = ~(s1_op1 & s1_op2);
      OP_NOR:  res = ~(s1_op1 | s1_op2);
      OP_NOT:  res = ~s1_op1;
      OP_PASS: res = s1_op1;
      default: res = '0;
    endcase
  end

  assign res_zero   = (res == '0);
  assign res_ones   = (res == '1);
  assign res_parity = ^res;

`ifdef LOGIC_UNIT_POPCNT_EN
  logic [PCW-1:0] res_pop;

  always_comb begin
    res_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_pop = res_pop + PCW'(res[i]);
    end
  end

  assign s2_in_data = {res, res_zero, res_ones, res_parity, res_pop};
  assign {out, zero, ones, parity, popcnt} = s2_out_data;
`else
  assign s2_in_data = {res, res_zero, res_ones, res_parity};
  assign {out, zero, ones, parity} = s2_out_data;
`endif

  logic_unit_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_data)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: fixed vectors on WIDTH=8 and WIDTH=13,
// backpressure and mid-flight reset sequences, randomized scoreboard run.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  op1_8, op2_8, out8;
  logic [2:0]  opsel8;
  logic        zero8, ones8, parity8;

  logic        in_valid13, in_ready13, out_valid13, out_ready13;
  logic [12:0] op1_13, op2_13, out13;
  logic [2:0]  opsel13;
  logic        zero13, ones13, parity13;

`ifdef LOGIC_UNIT_POPCNT_EN
  logic [3:0]  popcnt8;
  logic [3:0]  popcnt13;
`endif

  int checks = 0;
  int passes = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .opsel(opsel8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zero(zero8), .ones(ones8), .parity(parity8)
`ifdef LOGIC_UNIT_POPCNT_EN
    , .popcnt(popcnt8)
`endif
  );

  logic_unit_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid13), .in_ready(in_ready13),
    .op1(op1_13), .op2(op2_13), .opsel(opsel13),
    .out_valid(out_valid13), .out_ready(out_ready13),
    .out(out13), .zero(zero13), .ones(ones13), .parity(parity13)
`ifdef LOGIC_UNIT_POPCNT_EN
    , .popcnt(popcnt13)
`endif
  );

  typedef struct {
    logic [2:0]  sel;
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] res;
    logic        z;
    logic        o;
    logic        p;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    int         acc;
  } sb_t;

  vec_t v8[11];
  vec_t v13[4];
  sb_t  sb[$];

  // Behavioural reference: the opcode table applied to WIDTH-masked operands
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] sel,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (sel)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a ^ b);
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    return r & mask;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic applyStimulus(input int unit, input logic iv, input logic [12:0] a,
                               input logic [12:0] b, input logic [2:0] sel, input logic ordy);
    if (unit == 8) begin
      in_valid8 = iv; op1_8 = a[7:0]; op2_8 = b[7:0]; opsel8 = sel; out_ready8 = ordy;
    end else begin
      in_valid13 = iv; op1_13 = a; op2_13 = b; opsel13 = sel; out_ready13 = ordy;
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic runVec(input int unit, input vec_t v, input string tag);
    logic        ov, z, o, p;
    logic [12:0] r;
    applyStimulus(unit, 1'b1, v.a, v.b, v.sel, 1'b1);
    step();
    applyStimulus(unit, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    ov = (unit == 8) ? out_valid8 : out_valid13;
    checkOutput({tag, "_latency_valid"}, ov, 1'b0);
    step();
    ov = (unit == 8) ? out_valid8 : out_valid13;
    r  = (unit == 8) ? {5'd0, out8} : out13;
    z  = (unit == 8) ? zero8 : zero13;
    o  = (unit == 8) ? ones8 : ones13;
    p  = (unit == 8) ? parity8 : parity13;
    checkOutput({tag, "_valid"}, ov, 1'b1);
    checkOutput({tag, "_out"}, r, v.res);
    checkOutput({tag, "_zero"}, z, v.z);
    checkOutput({tag, "_ones"}, o, v.o);
    checkOutput({tag, "_parity"}, p, v.p);
`ifdef LOGIC_UNIT_POPCNT_EN
    checkOutput({tag, "_popcnt"}, (unit == 8) ? popcnt8 : popcnt13, $countones(v.res));
`endif
    step();
    ov = (unit == 8) ? out_valid8 : out_valid13;
    checkOutput({tag, "_drained"}, ov, 1'b0);
  endtask

  initial begin
    logic [2:0] bp_sel[4];
    logic [7:0] bp_exp[4];
    logic [7:0] got[$];
    int         accepted;
    logic       in_fire, out_fire, iv, ordy;
    logic [7:0] a, b, r;
    logic [2:0] sel;

    v8[0]  = '{3'b011, 13'hAA, 13'hAA, 13'hFF, 1'b0, 1'b1, 1'b0};
    v8[1]  = '{3'b011, 13'hF0, 13'h0F, 13'h00, 1'b1, 1'b0, 1'b0};
    v8[2]  = '{3'b100, 13'hF0, 13'h3C, 13'hCF, 1'b0, 1'b0, 1'b0};
    v8[3]  = '{3'b000, 13'hC3, 13'h5A, 13'h42, 1'b0, 1'b0, 1'b0};
    v8[4]  = '{3'b001, 13'hC3, 13'h5A, 13'hDB, 1'b0, 1'b0, 1'b0};
    v8[5]  = '{3'b010, 13'hC3, 13'h5A, 13'h99, 1'b0, 1'b0, 1'b0};
    v8[6]  = '{3'b101, 13'hC3, 13'h5A, 13'h24, 1'b0, 1'b0, 1'b0};
    v8[7]  = '{3'b110, 13'h3C, 13'hFF, 13'hC3, 1'b0, 1'b0, 1'b0};
    v8[8]  = '{3'b111, 13'h81, 13'h7E, 13'h81, 1'b0, 1'b0, 1'b0};
    v8[9]  = '{3'b001, 13'h01, 13'h00, 13'h01, 1'b0, 1'b0, 1'b1};
    v8[10] = '{3'b010, 13'h07, 13'h00, 13'h07, 1'b0, 1'b0, 1'b1};

    v13[0] = '{3'b101, 13'h0000, 13'h0000, 13'h1FFF, 1'b0, 1'b1, 1'b1};
    v13[1] = '{3'b110, 13'h1FFF, 13'h0000, 13'h0000, 1'b1, 1'b0, 1'b0};
    v13[2] = '{3'b100, 13'h1FFF, 13'h1FFF, 13'h0000, 1'b1, 1'b0, 1'b0};
    v13[3] = '{3'b011, 13'h0000, 13'h0001, 13'h1FFE, 1'b0, 1'b0, 1'b0};

    bp_sel = '{3'b000, 3'b001, 3'b010, 3'b101};
    bp_exp = '{8'h42, 8'hDB, 8'h99, 8'h24};

    // Reset held with input offered: nothing may be accepted or emerge
    rst_n = 1'b0;
    applyStimulus(8, 1'b1, 13'hAA, 13'hAA, 3'b011, 1'b1);
    applyStimulus(13, 1'b1, 13'h0, 13'h0, 3'b101, 1'b1);
    step();
    step();
    checkOutput("rst_out_valid", out_valid8, 1'b0);
    checkOutput("rst_out", out8, 8'h00);
    checkOutput("rst_zero", zero8, 1'b0);
    checkOutput("rst_ones", ones8, 1'b0);
    checkOutput("rst_parity", parity8, 1'b0);
    checkOutput("rst_out_valid13", out_valid13, 1'b0);
`ifdef LOGIC_UNIT_POPCNT_EN
    checkOutput("rst_popcnt", popcnt8, 4'd0);
`endif
    applyStimulus(8, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    applyStimulus(13, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    rst_n = 1'b1;
    step();
    checkOutput("rst_release_in_ready", in_ready8, 1'b1);
    checkOutput("rst_release_out_valid", out_valid8, 1'b0);

    for (int i = 0; i < 11; i++) runVec(8, v8[i], $sformatf("w8_vec%0d", i));
    for (int i = 0; i < 4; i++) runVec(13, v13[i], $sformatf("w13_vec%0d", i));

    // Backpressure: four ops offered while the consumer stalls
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8, accepted < 4, 13'hC3, 13'h5A, bp_sel[accepted < 4 ? accepted : 0], 1'b0);
      in_fire = in_valid8 && in_ready8;
      if (c >= 2) begin
        checkOutput($sformatf("bp_in_ready_c%0d", c), in_ready8, 1'b0);
        checkOutput($sformatf("bp_out_valid_c%0d", c), out_valid8, 1'b1);
        checkOutput($sformatf("bp_out_held_c%0d", c), out8, 8'h42);
      end
      step();
      if (in_fire) accepted++;
    end
    checkOutput("bp_accepted_while_stalled", accepted, 2);
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      applyStimulus(8, accepted < 4, 13'hC3, 13'h5A, bp_sel[accepted < 4 ? accepted : 0], 1'b1);
      in_fire  = in_valid8 && in_ready8;
      out_fire = out_valid8 && out_ready8;
      if (out_fire) got.push_back(out8);
      step();
      if (in_fire) accepted++;
    end
    checkOutput("bp_result_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checkOutput($sformatf("bp_order%0d", i), got[i], bp_exp[i]);
    end
    applyStimulus(8, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    step();
    step();

    // Reset with two ops in flight must discard both
    applyStimulus(8, 1'b1, 13'hC3, 13'h5A, 3'b000, 1'b0);
    step();
    applyStimulus(8, 1'b1, 13'hC3, 13'h5A, 3'b001, 1'b0);
    step();
    checkOutput("mr_pre_valid", out_valid8, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_async_valid", out_valid8, 1'b0);
    checkOutput("mr_async_out", out8, 8'h00);
    applyStimulus(8, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("mr_no_stale_c%0d", c), out_valid8, 1'b0);
      step();
    end
    applyStimulus(8, 1'b1, 13'hC3, 13'h5A, 3'b010, 1'b1);
    step();
    applyStimulus(8, 1'b0, 13'h0, 13'h0, 3'd0, 1'b1);
    step();
    checkOutput("mr_next_valid", out_valid8, 1'b1);
    checkOutput("mr_next_out", out8, 8'h99);
    step();
    checkOutput("mr_next_drained", out_valid8, 1'b0);

    // Randomized traffic against a FIFO scoreboard
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a    = 8'($urandom);
      b    = 8'($urandom);
      sel  = 3'($urandom);
      applyStimulus(8, iv, {5'd0, a}, {5'd0, b}, sel, ordy);
      checkOutput("rnd_in_ready", in_ready8, (sb.size() < 2) || ordy);
      checkOutput("rnd_out_valid", out_valid8, (sb.size() > 0) && (edges - sb[0].acc >= 1));
      if (out_valid8 && sb.size() > 0) begin
        r = sb[0].res;
        checkOutput("rnd_out", out8, r);
        checkOutput("rnd_zero", zero8, r == 8'h00);
        checkOutput("rnd_ones", ones8, r == 8'hFF);
        checkOutput("rnd_parity", parity8, $countones(r) % 2);
`ifdef LOGIC_UNIT_POPCNT_EN
        checkOutput("rnd_popcnt", popcnt8, $countones(r));
`endif
      end
      in_fire  = iv && in_ready8;
      out_fire = out_valid8 && ordy;
      step();
      if (out_fire && sb.size() > 0) void'(sb.pop_front());
      if (in_fire) sb.push_back('{8'(ref_op(8, sel, {56'd0, a}, {56'd0, b})), edges});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
